fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 reset  input  1  asynchronous active-low reset; 0 = in reset.
REQ-004 StallD  input  1  decode stage cannot accept a new instruction this cycle.
REQ-005 FlushD  input  1  invalidate the fetch/decode register this cycle.
REQ-006 BranchTakenE  input  1  branch resolved taken in execute.
REQ-007 ALUResultE  input  32  branch target from execute.
REQ-008 PCSrcW  input  1  write to PC (R15) from writeback.
REQ-009 ResultW  input  32  PC target from writeback.
REQ-010 imem_req  output  1  instruction memory request.
REQ-011 imem_addr  output  32  word address of request, equal to PCF.
REQ-012 imem_ack  input  1  response valid; imem_rdata is valid in the same cycle.
REQ-013 imem_rdata  input  32  instruction word.
REQ-014 InstrD  output  32  registered instruction to decode.
REQ-015 PCPlus8D  output  32  registered fetch PC + 8, used as the R15 read value.
REQ-016 ValidD  output  1  InstrD holds a real instruction.
REQ-017 FetchCount  output  32  count of instructions delivered to decode; see Configuration.

Function
REQ-018 FSM states: F_REQ (request outstanding) and F_HOLD (word buffered, decode stalled).
REQ-019 F_REQ: imem_req=1; imem_addr=PCF, held stable until imem_ack.
REQ-020 F_REQ, ack, no redirect, StallD=0: InstrD<=imem_rdata, PCPlus8D<=PCF+8, ValidD<=1, PCF<=PCF+4, stay in F_REQ.
REQ-021 F_REQ, ack, no redirect, StallD=1: word and PCF+8 go into the skid buffer; PCF<=PCF+4; next state F_HOLD.
REQ-022 F_HOLD: imem_req=0; when StallD=0, the buffer moves to the D register (ValidD<=1); next state F_REQ.
REQ-023 Redirect target priority: BranchTakenE (ALUResultE) over PCSrcW (ResultW).
REQ-024 Redirect in F_REQ without ack: latch the target in a pending register; imem_addr stays unchanged.
REQ-025 Ack with a redirect in the same cycle or pending: discard the response; PCF<=target; clear pending; stay in F_REQ; D register unchanged.
REQ-026 Redirect in F_HOLD: drop the buffer; PCF<=target; next state F_REQ.
REQ-027 Target bits [1:0] are forced to 0; all PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-028 FlushD=1: ValidD<=0, InstrD<=NOP_INSTR at the next edge. FlushD overrides StallD and any transfer.
REQ-029 StallD=1 and FlushD=0: the D register holds its value.
REQ-030 The stage never issues a second request before the current one is acked (single outstanding).

Reset
REQ-031 On reset=0, asynchronously: PCF=RESET_PC, state F_REQ, pending cleared, buffer invalid.
REQ-032 On reset=0, asynchronously: InstrD=NOP_INSTR, PCPlus8D=RESET_PC+8, ValidD=0, FetchCount=0.
REQ-033 imem_req is 0 during reset. The first request is issued in the first cycle after reset deasserts.
REQ-034 Reset mid-request abandons the request; any late ack after reset is treated as the response to the new RESET_PC request only if it arrives with imem_req=1.

Configuration
REQ-035 Macro FETCH_PERF_CNT_EN defined: FetchCount increments by 1 on every transfer into D with ValidD<=1, and wraps at 2^32.
REQ-036 Macro FETCH_PERF_CNT_EN undefined: FetchCount is tied to 0 and no counter logic exists.

Structure
REQ-037 Package arm_pkg holds: fetch_state_t enum, NOP_INSTR (32'hE1A0_0000), PC_STEP (4), PC_R15_OFFSET (8).
REQ-038 The fetch/decode register (InstrD, PCPlus8D, ValidD, with stall and flush) is a separate sub-module named pipeFetchDeco.

Verification
REQ-039 Release reset, ack every cycle with rdata=addr -> InstrD sequence 0,4,8; PCPlus8D sequence 8,12,16; ValidD=1.
REQ-040 StallD=1 for 3 cycles during an ack -> F_HOLD, imem_req=0, D held; release -> buffered word appears once, none lost.
REQ-041 BranchTakenE=1, ALUResultE=32'h100, with a request pending and ack 2 cycles later -> response discarded; next imem_addr=32'h100.
REQ-042 BranchTakenE and PCSrcW in the same cycle (targets 32'h200, 32'h300) -> next imem_addr=32'h200.
REQ-043 FlushD=1 together with StallD=1 -> ValidD=0, InstrD=32'hE1A0_0000.
REQ-044 With FETCH_PERF_CNT_EN, 10 deliveries and 2 flushes -> FetchCount=10; reset low mid-run -> FetchCount=0 and imem_addr=RESET_PC.

Source files
------------

// File: rtl/arm_pkg.sv
// arm_pkg -- shared definitions for the fetch stage.
//
// Contents:
//   fetch_state_t  : fetch FSM states
//                    F_REQ  = request outstanding
//                    F_HOLD = fetched word parked in the skid buffer
//   NOP_INSTR      : MOV r0, r0, the bubble placed in decode on a flush
//   PC_STEP        : byte distance between sequential instructions
//   PC_R15_OFFSET  : ARM reads R15 as the fetch address plus 8
//   align_word()   : clears bits [1:0] so every PC is word aligned
package arm_pkg;

  typedef enum logic [0:0] {
    F_REQ  = 1'b0,
    F_HOLD = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR     = 32'hE1A0_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] PC_R15_OFFSET = 32'd8;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if -- instruction memory request/response bus.
//
// Signals:
//   imem_req   : fetch stage has a request outstanding
//   imem_addr  : word address of the request (held until acked)
//   imem_ack   : response valid this cycle
//   imem_rdata : instruction word, valid together with imem_ack
//
// Modports:
//   master : the fetch stage (drives req/addr)
//   slave  : the instruction memory (drives ack/rdata)
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/pipeFetchDeco.sv
// pipeFetchDeco -- fetch/decode pipeline register.
//
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   StallD        : decode cannot take a new word; register holds
//   FlushD        : replace the contents with a NOP bubble
//   offer_valid   : the fetch side presents a word this cycle
//   offer_instr   : presented instruction word
//   offer_pc8     : presented fetch PC + 8
//   InstrD        : registered instruction
//   PCPlus8D      : registered fetch PC + 8 (R15 read value)
//   ValidD        : InstrD holds a real instruction
//
// A presented word is taken only when decode is not stalled. With no word
// presented the register keeps its previous contents.
module pipeFetchDeco
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        offer_valid,
  input  logic [31:0] offer_instr,
  input  logic [31:0] offer_pc8,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus8D,
  output logic        ValidD
);

  // Flush beats both stall and a pending transfer so a squashed slot can
  // never leak a stale instruction into decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      InstrD   <= NOP_INSTR;
      PCPlus8D <= RESET_PC + PC_R15_OFFSET;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP_INSTR;
      ValidD <= 1'b0;
    end else if (offer_valid && !StallD) begin
      InstrD   <= offer_instr;
      PCPlus8D <= offer_pc8;
      ValidD   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage -- ARM-style instruction fetch with a one-entry skid buffer.
//
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   StallD        : decode cannot accept a new instruction
//   FlushD        : invalidate the fetch/decode register
//   BranchTakenE  : redirect to ALUResultE (highest priority)
//   ALUResultE    : branch target from execute
//   PCSrcW        : redirect to ResultW (write to R15)
//   ResultW       : PC target from writeback
//   imem          : instruction memory bus (fetch_stage_if.master)
//   InstrD        : instruction to decode
//   PCPlus8D      : fetch PC + 8 of InstrD
//   ValidD        : InstrD is a real instruction
//   FetchCount    : instructions delivered to decode
//
// Build option:
//   FETCH_PERF_CNT_EN : when defined, FetchCount counts every delivery into
//                       decode (wrapping at 2^32); otherwise it is tied to 0.
//
// Only one memory request is ever outstanding. A redirect that arrives while
// waiting for a response is remembered, and the response that eventually
// arrives is thrown away because it belongs to the abandoned path.
module fetch_stage
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          BranchTakenE,
  input  logic [31:0]   ALUResultE,
  input  logic          PCSrcW,
  input  logic [31:0]   ResultW,
  fetch_stage_if.master imem,
  output logic [31:0]   InstrD,
  output logic [31:0]   PCPlus8D,
  output logic          ValidD,
  output logic [31:0]   FetchCount
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic         pend_valid_q;
  logic [31:0]  pend_target_q;
  logic [31:0]  buf_instr_q;
  logic [31:0]  buf_pc8_q;

  logic         redirect;
  logic [31:0]  redirect_target;
  logic         ack;
  logic         offer_valid;
  logic [31:0]  offer_instr;
  logic [31:0]  offer_pc8;

  // Execute is younger in program order than writeback's R15 write only in
  // the sense that it resolves the control flow decode must follow next,
  // so its target wins when both fire together.
  always_comb begin
    redirect        = BranchTakenE | PCSrcW;
    redirect_target = align_word(BranchTakenE ? ALUResultE : ResultW);
  end

  // The request is masked by reset directly so the bus is quiet while reset
  // is held and the first request appears as soon as reset is released.
  assign imem.imem_req  = reset & (state_q == F_REQ);
  assign imem.imem_addr = pc_q;
  assign ack            = imem.imem_ack & imem.imem_req;

  // A word is presented to the decode register either straight from memory
  // (on-path response) or from the skid buffer once decode frees up.
  always_comb begin
    offer_valid = 1'b0;
    offer_instr = imem.imem_rdata;
    offer_pc8   = pc_q + PC_R15_OFFSET;
    if (state_q == F_HOLD) begin
      offer_valid = ~redirect;
      offer_instr = buf_instr_q;
      offer_pc8   = buf_pc8_q;
    end else begin
      offer_valid = ack & ~redirect & ~pend_valid_q;
    end
  end

  // Fetch FSM: PC sequencing, pending redirect capture and the skid buffer.
  // The buffer is only meaningful in F_HOLD, so no separate valid bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= F_REQ;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= RESET_PC;
      buf_instr_q   <= NOP_INSTR;
      buf_pc8_q     <= RESET_PC + PC_R15_OFFSET;
    end else begin
      case (state_q)
        F_REQ: begin
          if (ack) begin
            pend_valid_q <= 1'b0;
            if (redirect) begin
              pc_q <= redirect_target;
            end else if (pend_valid_q) begin
              pc_q <= pend_target_q;
            end else begin
              pc_q <= pc_q + PC_STEP;
              if (StallD) begin
                buf_instr_q <= imem.imem_rdata;
                buf_pc8_q   <= pc_q + PC_R15_OFFSET;
                state_q     <= F_HOLD;
              end
            end
          end else if (redirect) begin
            pend_valid_q  <= 1'b1;
            pend_target_q <= redirect_target;
          end
        end
        F_HOLD: begin
          if (redirect) begin
            pc_q    <= redirect_target;
            state_q <= F_REQ;
          end else if (!StallD) begin
            state_q <= F_REQ;
          end
        end
        default: state_q <= F_REQ;
      endcase
    end
  end

  pipeFetchDeco #(
    .RESET_PC (RESET_PC)
  ) u_pipe_fetch_deco (
    .clk         (clk),
    .reset       (reset),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .offer_valid (offer_valid),
    .offer_instr (offer_instr),
    .offer_pc8   (offer_pc8),
    .InstrD      (InstrD),
    .PCPlus8D    (PCPlus8D),
    .ValidD      (ValidD)
  );

`ifdef FETCH_PERF_CNT_EN
  logic        deliver;
  logic [31:0] fetch_count_q;

  assign deliver = offer_valid & ~StallD & ~FlushD;

  // Counts only words that actually land in decode as valid instructions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= 32'd0;
    end else if (deliver) begin
      fetch_count_q <= fetch_count_q + 32'd1;
    end
  end

  assign FetchCount = fetch_count_q;
`else
  assign FetchCount = 32'd0;
`endif

endmodule
